// File: rtl/ifft2_stream_pkg.sv
// Shared types and constants for the inverse radix-2 butterfly stream.
// Holds the FSM state type, the complex sample struct and the saturating clamp.
package ifft_pkg;

  localparam int SAMPLE_W = 16;
  localparam logic signed [SAMPLE_W:0] SAT_MAX = 17'sd32767;
  localparam logic signed [SAMPLE_W:0] SAT_MIN = -17'sd32768;

  typedef enum logic [1:0] {
    S_SUM  = 2'd0,
    S_DIFF = 2'd1,
    OUT_A  = 2'd2,
    OUT_B  = 2'd3
  } state_t;

  typedef struct packed {
    logic [SAMPLE_W-1:0] r;
    logic [SAMPLE_W-1:0] i;
  } cplx_t;

  // Returns {clipped, value} for a 17-bit signed intermediate.
  function automatic logic [SAMPLE_W:0] sat16(input logic signed [SAMPLE_W:0] v);
    logic [SAMPLE_W:0] res;
    if (v > SAT_MAX) begin
      res = {1'b1, 16'h7FFF};
    end else if (v < SAT_MIN) begin
      res = {1'b1, 16'h8000};
    end else begin
      res = {1'b0, v[SAMPLE_W-1:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/ifft2_core.sv
// Combinational recombine of a sum/diff pair: A = s + d, B = s - d,
// each widened to 17 bits, arithmetically shifted, then clamped to 16 bits.
module ifft2_core
  import ifft_pkg::*;
#(
  parameter int SHIFT = 0
) (
  input  cplx_t       sum,
  input  cplx_t       diff,
  output cplx_t       a,
  output cplx_t       b,
  output logic [3:0]  clip
);

  logic signed [SAMPLE_W:0] ar_s, ai_s, br_s, bi_s;
  logic [SAMPLE_W:0] ar_q, ai_q, br_q, bi_q;

  // Widen, combine, shift.
  always_comb begin
    ar_s = ($signed({sum.r[SAMPLE_W-1], sum.r}) + $signed({diff.r[SAMPLE_W-1], diff.r})) >>> SHIFT;
    ai_s = ($signed({sum.i[SAMPLE_W-1], sum.i}) + $signed({diff.i[SAMPLE_W-1], diff.i})) >>> SHIFT;
    br_s = ($signed({sum.r[SAMPLE_W-1], sum.r}) - $signed({diff.r[SAMPLE_W-1], diff.r})) >>> SHIFT;
    bi_s = ($signed({sum.i[SAMPLE_W-1], sum.i}) - $signed({diff.i[SAMPLE_W-1], diff.i})) >>> SHIFT;
  end

  // Clamp each component and collect the clip flags.
  always_comb begin
    ar_q = sat16(ar_s);
    ai_q = sat16(ai_s);
    br_q = sat16(br_s);
    bi_q = sat16(bi_s);
    a.r  = ar_q[SAMPLE_W-1:0];
    a.i  = ai_q[SAMPLE_W-1:0];
    b.r  = br_q[SAMPLE_W-1:0];
    b.i  = bi_q[SAMPLE_W-1:0];
    clip = {bi_q[SAMPLE_W], br_q[SAMPLE_W], ai_q[SAMPLE_W], ar_q[SAMPLE_W]};
  end

endmodule

// File: rtl/ifft2_stream.sv
// Streaming inverse radix-2 butterfly: takes a sum beat then a diff beat and
// emits the reconstructed pair A then B, with a sticky saturation flag.
module ifft2_stream
  import ifft_pkg::*;
#(
  parameter int SHIFT = 0
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SAMPLE_W-1:0] in_r,
  input  logic [SAMPLE_W-1:0] in_i,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SAMPLE_W-1:0] out_r,
  output logic [SAMPLE_W-1:0] out_i,
  output logic                out_last,
  output logic                sat,
  input  logic                sat_clr
);

  state_t     state_r;
  cplx_t      sum_r, diff_r, b_r;
  cplx_t      in_s, core_diff_s, a_s, b_s;
  logic [3:0] clip_s;
  logic       in_ready_r, out_valid_r, out_last_r, sat_r;
  logic [SAMPLE_W-1:0] out_re_r, out_im_r;
  logic       take_sum_s, take_diff_s;

  assign in_s.r = in_r;
  assign in_s.i = in_i;

  // Handshake decode for the two input beats.
  always_comb begin
    take_sum_s  = 1'b0;
    take_diff_s = 1'b0;
    if (in_valid && in_ready_r) begin
      take_sum_s  = (state_r == S_SUM);
      take_diff_s = (state_r == S_DIFF);
    end else begin
      take_sum_s  = 1'b0;
      take_diff_s = 1'b0;
    end
    core_diff_s = take_diff_s ? in_s : diff_r;
  end

  ifft2_core #(.SHIFT(SHIFT)) u_core (
    .sum  (sum_r),
    .diff (core_diff_s),
    .a    (a_s),
    .b    (b_s),
    .clip (clip_s)
  );

  // Pair sequencing and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r     <= S_SUM;
      sum_r       <= '0;
      diff_r      <= '0;
      b_r         <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_re_r    <= 16'h0000;
      out_im_r    <= 16'h0000;
    end else begin
      case (state_r)
        S_SUM: begin
          if (take_sum_s) begin
            sum_r   <= in_s;
            state_r <= S_DIFF;
          end
        end
        S_DIFF: begin
          if (take_diff_s) begin
            diff_r      <= in_s;
            b_r         <= b_s;
            out_re_r    <= a_s.r;
            out_im_r    <= a_s.i;
            out_valid_r <= 1'b1;
            out_last_r  <= 1'b0;
            in_ready_r  <= 1'b0;
            state_r     <= OUT_A;
          end
        end
        OUT_A: begin
          if (out_ready) begin
            out_re_r   <= b_r.r;
            out_im_r   <= b_r.i;
            out_last_r <= 1'b1;
            state_r    <= OUT_B;
          end
        end
        OUT_B: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= S_SUM;
          end
        end
        default: begin
          state_r     <= S_SUM;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          out_last_r  <= 1'b0;
        end
      endcase
    end
  end

  // Sticky saturation flag; a new clip event beats a simultaneous clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sat_r <= 1'b0;
    end else if (take_diff_s && (|clip_s)) begin
      sat_r <= 1'b1;
    end else if (sat_clr) begin
      sat_r <= 1'b0;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;
  assign out_r     = out_re_r;
  assign out_i     = out_im_r;
  assign sat       = sat_r;

endmodule
